// File: rtl/counter_ctrl.sv
// Sequencing FSM driving clear/enable of an external up-counter for one-shot and periodic jobs.
// Optional completed-period counter built only when CNT_CTRL_PERIOD_CNT_EN is defined.
module counter_ctrl #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [WIDTH-1:0]  limit_i,
    input  logic              periodic_i,
    input  logic              pause_i,
    input  logic              abort_i,
    input  logic [WIDTH-1:0]  count_i,
    output logic              cnt_clr_o,
    output logic              cnt_en_o,
    output logic              busy_o,
    output logic              ack_o,
    output logic              tc_o,
    output logic              done_o,
    output logic [PCNT_W-1:0] period_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             periodic_q, periodic_d;
    logic             ack_q, ack_d;
    logic             match;

    // A paused counter sitting on the limit must not report terminal count.
    assign match = (count_i == limit_q) && !pause_i;

    always_comb begin
        state_d    = state_q;
        limit_d    = limit_q;
        periodic_d = periodic_q;
        ack_d      = 1'b0;
        cnt_clr_o  = 1'b0;
        cnt_en_o   = 1'b0;
        tc_o       = 1'b0;
        done_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_clr_o = 1'b1;
                if (start_i) begin
                    limit_d    = limit_i;
                    periodic_d = periodic_i;
                    ack_d      = 1'b1;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_clr_o = 1'b1;
                state_d   = abort_i ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (match) begin
                    tc_o = 1'b1;
                    if (periodic_q) begin
                        cnt_clr_o = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_en_o = !pause_i;
                end
            end
            S_DONE: begin
                done_o  = !abort_i;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
            ack_q      <= ack_d;
        end
    end

    assign ack_o  = ack_q;
    assign busy_o = (state_q != S_IDLE);

`ifdef CNT_CTRL_PERIOD_CNT_EN
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;

    // Restart on accepted job, count each periodic wrap, hold at all-ones.
    always_comb begin
        pcnt_d = pcnt_q;
        if (state_q == S_IDLE && start_i) begin
            pcnt_d = '0;
        end else if (state_q == S_RUN && !abort_i && match && periodic_q && (pcnt_q != '1)) begin
            pcnt_d = pcnt_q + {{(PCNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign period_cnt_o = pcnt_q;
`else
    assign period_cnt_o = '0;
`endif

endmodule
